gf180mcu_fd_sc_mcu7t5v0__parity_chk: RTL and testbench

Serial frame parity checker for the 7-track 5V cell set. It is the receive end of the XNOR-parity scheme. The transmit side appends PAR, the XNOR of every data bit in the frame, so data plus PAR always carries an odd number of ones. This block accepts DATA_W-bit beats over a valid/ready handshake and accumulates their parity. On the last beat it checks PAR, then reports a parity or length error with a saturating error count.

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__parity_pkg.sv | 20 ++
 rtl/gf180mcu_fd_sc_mcu7t5v0__parity_acc.sv | 42 ++++
 rtl/gf180mcu_fd_sc_mcu7t5v0__parity_chk.sv | 126 ++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__parity_chk.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__parity_pkg.sv
// Shared types, defaults and helpers for the XNOR frame-parity checker.
// The FSM state encoding and the saturating counter step live here.
package gf180mcu_fd_sc_mcu7t5v0__parity_pkg;

    localparam int DEF_DATA_W      = 3;
    localparam int DEF_FRAME_BEATS = 8;
    localparam int DEF_CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC    = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__parity_acc.sv
// Running parity accumulator: loads ^d on the first beat, folds in ^d on later beats.
// acc_nxt already includes the current beat, so the checker can test it on the closing beat.
module gf180mcu_fd_sc_mcu7t5v0__parity_acc
    import gf180mcu_fd_sc_mcu7t5v0__parity_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              accum,
    input  logic [DATA_W-1:0] d,
    output logic              acc_nxt
);

    logic acc_q;
    logic acc_d;
    logic beat_par;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        beat_par = ^d;
        acc_d    = acc_q;
        if (load) begin
            acc_d = beat_par;
        end else if (accum) begin
            acc_d = acc_q ^ beat_par;
        end
    end

    assign acc_nxt = acc_d;

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__parity_chk.sv
// Receive-side XNOR frame-parity checker: accumulates beat parity, checks PAR and
// frame length on the closing beat, and keeps a saturating count of bad frames.
module gf180mcu_fd_sc_mcu7t5v0__parity_chk
    import gf180mcu_fd_sc_mcu7t5v0__parity_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int FRAME_BEATS = DEF_FRAME_BEATS,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] D,
    input  logic              VLD,
    input  logic              LAST,
    input  logic              PAR,
    input  logic              CLR,
    output logic              RDY,
    output logic              DONE,
    output logic              ERR,
    output logic              LEN_ERR,
    output logic [CNT_W-1:0]  ERR_CNT
);

    localparam int                 BCNT_W    = $clog2(FRAME_BEATS + 1);
    localparam logic [BCNT_W-1:0]  BEATS_MAX = BCNT_W'(FRAME_BEATS);
    localparam logic [31:0]        CNT_MAX   = 32'({CNT_W{1'b1}});

    state_e             state_q, state_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic [BCNT_W-1:0]  beat_num;
    logic               rdy_q, rdy_d;
    logic               err_q, err_d;
    logic               len_err_q, len_err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               accept;
    logic               frame_end;
    logic               acc_load;
    logic               acc_accum;
    logic               acc_nxt;

    // Beat bookkeeping is kept outside the FSM block so the accumulator's
    // combinational output can feed back into it without forming a loop.
    assign accept    = VLD & rdy_q;
    assign beat_num  = (state_q == ST_ACC) ? bcnt_q + 1'b1 : BCNT_W'(1);
    assign frame_end = accept & (LAST | (beat_num == BEATS_MAX));
    assign acc_load  = accept & (state_q == ST_IDLE);
    assign acc_accum = accept & (state_q == ST_ACC);

    gf180mcu_fd_sc_mcu7t5v0__parity_acc #(
        .DATA_W (DATA_W)
    ) u_acc (
        .clk     (CLK),
        .rst     (RST),
        .load    (acc_load),
        .accum   (acc_accum),
        .d       (D),
        .acc_nxt (acc_nxt)
    );

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        err_d     = 1'b0;
        len_err_d = 1'b0;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    bcnt_d  = beat_num;
                    state_d = frame_end ? ST_REPORT : ST_ACC;
                end
            end
            ST_ACC: begin
                if (accept) begin
                    bcnt_d = beat_num;
                    if (frame_end) begin
                        state_d = ST_REPORT;
                    end
                end
            end
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Data plus PAR must carry an odd number of ones; even means corruption.
        if (frame_end) begin
            err_d     = ~(acc_nxt ^ PAR);
            len_err_d = ~LAST | (beat_num != BEATS_MAX);
        end

        if (frame_end & (err_d | len_err_d)) begin
            err_cnt_d = CLR ? CNT_W'(1) : CNT_W'(sat_inc(32'(err_cnt_q), CNT_MAX));
        end else if (CLR) begin
            err_cnt_d = '0;
        end

        // RDY is registered so it can be held low through reset and REPORT.
        rdy_d = (state_d != ST_REPORT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            bcnt_q    <= '0;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
            len_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            rdy_q     <= rdy_d;
            err_q     <= err_d;
            len_err_q <= len_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign RDY     = rdy_q;
    assign DONE    = (state_q == ST_REPORT);
    assign ERR     = err_q;
    assign LEN_ERR = len_err_q;
    assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__parity_chk.sv
// Scoreboard bench for the frame-parity checker with DATA_W=3, FRAME_BEATS=2.
// Expected reports are pushed when the closing beat is accepted and popped on DONE.
module tb_gf180mcu_fd_sc_mcu7t5v0__parity_chk;

    localparam int DATA_W = 3;
    localparam int FB     = 2;
    localparam int CNT_W  = 8;

    logic              clk  = 1'b0;
    logic              rst  = 1'b1;
    logic [DATA_W-1:0] d    = '0;
    logic              vld  = 1'b0;
    logic              last = 1'b0;
    logic              par  = 1'b0;
    logic              clr  = 1'b0;
    logic              rdy, done, err, len_err;
    logic [CNT_W-1:0]  err_cnt;

    typedef struct packed {
        logic             err;
        logic             len_err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    logic m_acc    = 1'b0;
    int   m_cnt    = 0;
    int   m_errcnt = 0;

    gf180mcu_fd_sc_mcu7t5v0__parity_chk #(
        .DATA_W      (DATA_W),
        .FRAME_BEATS (FB),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .D       (d),
        .VLD     (vld),
        .LAST    (last),
        .PAR     (par),
        .CLR     (clr),
        .RDY     (rdy),
        .DONE    (done),
        .ERR     (err),
        .LEN_ERR (len_err),
        .ERR_CNT (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required bench to finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard consumer: every DONE must match the oldest pending frame.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            vectors++;
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_done: DONE=1 with no frame pending, required DONE=0");
                end else begin
                    mon_e = sb_q.pop_front();
                    if ({err, len_err, err_cnt, rdy} !== {mon_e.err, mon_e.len_err, mon_e.cnt, 1'b0}) begin
                        miscompares++;
                        $display("FAIL done_report: ERR=%b LEN_ERR=%b ERR_CNT=%0d RDY=%b, required ERR=%b LEN_ERR=%b ERR_CNT=%0d RDY=0",
                                 err, len_err, err_cnt, rdy, mon_e.err, mon_e.len_err, mon_e.cnt);
                    end
                end
            end else if (done !== 1'b0 || err !== 1'b0 || len_err !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_flags: DONE=%b ERR=%b LEN_ERR=%b, required all 0", done, err, len_err);
            end
        end
    end

    task automatic model_reset();
        m_acc    = 1'b0;
        m_cnt    = 0;
        m_errcnt = 0;
        sb_q.delete();
    endtask

    task automatic model_accept(input logic [DATA_W-1:0] bd, input logic bl, input logic bp, input logic bc);
        logic e;
        logic l;
        m_acc = (m_cnt == 0) ? ^bd : m_acc ^ (^bd);
        m_cnt++;
        if (bl || m_cnt == FB) begin
            e = ~(m_acc ^ bp);
            l = !bl || m_cnt != FB;
            if (e || l) m_errcnt = bc ? 1 : ((m_errcnt == 255) ? 255 : m_errcnt + 1);
            else if (bc) m_errcnt = 0;
            sb_q.push_back('{err: e, len_err: l, cnt: CNT_W'(m_errcnt)});
            m_cnt = 0;
        end else if (bc) begin
            m_errcnt = 0;
        end
    endtask

    // Presents one beat, waits for RDY, and records the accepted beat in the model.
    task automatic send_beat(input logic [DATA_W-1:0] bd, input logic bl, input logic bp,
                             input logic bc, output int waits);
        @(negedge clk);
        d = bd; vld = 1'b1; last = bl; par = bp; waits = 0;
        while (rdy !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (rdy !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL rdy_timeout: RDY=%b after %0d cycles, required 1", rdy, waits);
            vld = 1'b0;
            return;
        end
        clr = bc;
        @(posedge clk);
        model_accept(bd, bl, bp, bc);
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({rdy, done, err, len_err} !== 4'b0000 || err_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_state: RDY=%b DONE=%b ERR=%b LEN_ERR=%b ERR_CNT=%0d, required all 0",
                     rdy, done, err, len_err, err_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (rdy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: RDY=%b DONE=%b, required RDY=1 DONE=0", rdy, done);
        end
    endtask

    task automatic test_good_frame();
        int w;
        send_beat(3'b101, 1'b0, 1'b0, 1'b0, w);
        send_beat(3'b011, 1'b1, 1'b1, 1'b0, w);
        @(negedge clk);
        vld = 1'b0; last = 1'b0;
        vectors++;
        if ({done, rdy, err, len_err} !== 4'b1000 || err_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL good_frame: DONE=%b RDY=%b ERR=%b LEN_ERR=%b ERR_CNT=%0d, required 1 0 0 0 0",
                     done, rdy, err, len_err, err_cnt);
        end
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL good_drain: %0d reports pending, required 0", sb_q.size());
        end
    endtask

    task automatic test_parity_error();
        int w;
        send_beat(3'b101, 1'b0, 1'b1, 1'b0, w);
        send_beat(3'b011, 1'b1, 1'b0, 1'b0, w);
        @(negedge clk);
        vld = 1'b0; last = 1'b0;
        vectors++;
        if ({done, err, len_err} !== 3'b110 || err_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL parity_error: DONE=%b ERR=%b LEN_ERR=%b ERR_CNT=%0d, required 1 1 0 1",
                     done, err, len_err, err_cnt);
        end
        send_beat(3'b110, 1'b0, 1'b0, 1'b0, w);
        send_beat(3'b001, 1'b1, 1'b0, 1'b0, w);
        @(negedge clk);
        vld = 1'b0; last = 1'b0;
        vectors++;
        if ({done, err, len_err} !== 3'b100 || err_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL good_after_error: DONE=%b ERR=%b LEN_ERR=%b ERR_CNT=%0d, required 1 0 0 1",
                     done, err, len_err, err_cnt);
        end
    endtask

    task automatic test_short_frame();
        int w;
        send_beat(3'b111, 1'b1, 1'b0, 1'b0, w);
        @(negedge clk);
        vld = 1'b0; last = 1'b0;
        vectors++;
        if ({done, rdy, err, len_err} !== 4'b1001 || err_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL short_frame: DONE=%b RDY=%b ERR=%b LEN_ERR=%b ERR_CNT=%0d, required 1 0 0 1 2",
                     done, rdy, err, len_err, err_cnt);
        end
        send_beat(3'b101, 1'b0, 1'b0, 1'b0, w);
        send_beat(3'b011, 1'b0, 1'b1, 1'b0, w);
        @(negedge clk);
        vld = 1'b0;
        vectors++;
        if ({done, err, len_err} !== 3'b101 || err_cnt !== 8'd3) begin
            miscompares++;
            $display("FAIL missing_last: DONE=%b ERR=%b LEN_ERR=%b ERR_CNT=%0d, required 1 0 1 3",
                     done, err, len_err, err_cnt);
        end
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL short_drain: %0d reports pending, required 0", sb_q.size());
        end
    endtask

    // VLD stays high throughout; the first beat of each later frame must wait out REPORT.
    task automatic test_back_to_back();
        int w0, w1;
        for (int f = 0; f < 4; f++) begin
            send_beat(3'b100 | 3'(f), 1'b0, 1'b0, 1'b0, w0);
            send_beat(3'b010, 1'b1, ~(^(3'b100 | 3'(f)) ^ 1'b1), 1'b0, w1);
            vectors++;
            if (w0 !== ((f == 0) ? 0 : 1) || w1 !== 0) begin
                miscompares++;
                $display("FAIL b2b_pattern: frame %0d waits=%0d,%0d, required %0d,0",
                         f, w0, w1, (f == 0) ? 0 : 1);
            end
        end
        @(negedge clk);
        vld = 1'b0; last = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain: %0d reports pending, required 0", sb_q.size());
        end
    endtask

    task automatic test_mid_frame_reset();
        int w;
        send_beat(3'b111, 1'b0, 1'b0, 1'b0, w);
        @(negedge clk);
        vld = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if ({rdy, done} !== 2'b00 || err_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL mid_reset: RDY=%b DONE=%b ERR_CNT=%0d, required 0 0 0", rdy, done, err_cnt);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send_beat(3'b011, 1'b0, 1'b0, 1'b0, w);
        send_beat(3'b101, 1'b1, 1'b1, 1'b0, w);
        @(negedge clk);
        vld = 1'b0; last = 1'b0;
        vectors++;
        if ({done, err, len_err} !== 3'b100 || err_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL fresh_frame: DONE=%b ERR=%b LEN_ERR=%b ERR_CNT=%0d, required 1 0 0 0",
                     done, err, len_err, err_cnt);
        end
    endtask

    task automatic test_saturation();
        int w;
        for (int i = 0; i < 258; i++) begin
            send_beat(3'b111, 1'b1, 1'b0, 1'b0, w);
        end
        @(negedge clk);
        vld = 1'b0; last = 1'b0;
        vectors++;
        if (done !== 1'b1 || err_cnt !== 8'd255) begin
            miscompares++;
            $display("FAIL saturate: DONE=%b ERR_CNT=%0d, required 1 255", done, err_cnt);
        end
        send_beat(3'b111, 1'b1, 1'b0, 1'b1, w);
        @(negedge clk);
        vld = 1'b0; last = 1'b0; clr = 1'b0;
        vectors++;
        if (done !== 1'b1 || err_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL clr_with_error: DONE=%b ERR_CNT=%0d, required 1 1", done, err_cnt);
        end
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        m_errcnt = 0;
        @(negedge clk);
        clr = 1'b0;
        vectors++;
        if (err_cnt !== 8'd0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_idle: ERR_CNT=%0d DONE=%b, required 0 0", err_cnt, done);
        end
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL sat_drain: %0d reports pending, required 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_short_frame();
        test_back_to_back();
        test_mid_frame_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
